// File: rtl/dispense_sequencer_pkg.sv
// Shared types and constants for the note dispense sequencer.
// Holds state encoding, denomination codes and values, and error codes.
package dispense_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_PLAN     = 3'd2,
        S_FEED     = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_DONE     = 3'd5,
        S_FAULT    = 3'd6
    } state_e;

    localparam logic [1:0] D500 = 2'd0;
    localparam logic [1:0] D200 = 2'd1;
    localparam logic [1:0] D100 = 2'd2;

    localparam logic [15:0] VAL500 = 16'd5;
    localparam logic [15:0] VAL200 = 16'd2;
    localparam logic [15:0] VAL100 = 16'd1;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_LIMIT = 2'd1;
    localparam logic [1:0] E_NOTES = 2'd2;
    localparam logic [1:0] E_JAM   = 2'd3;

    function automatic logic [1:0] pick_denom(
        input logic [7:0] p500,
        input logic [7:0] p200
    );
        if (p500 != 8'd0)      return D500;
        else if (p200 != 8'd0) return D200;
        else                   return D100;
    endfunction

endpackage

// File: rtl/dispense_sequencer_timeout.sv
// Per-note acknowledge watchdog: cleared by load, counts while run.
// expired flags the last allowed cycle of the wait window.
module note_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (run && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/dispense_sequencer.sv
// Cash dispense sequencer: plans a greedy note mix, then feeds notes
// one at a time, waiting for the exit sensor on each.
module dispense_sequencer
    import dispense_sequencer_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int MAX_NOTES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] amount,
    input  logic        note_ack,
    input  logic        load,
    input  logic [1:0]  load_sel,
    input  logic [7:0]  load_count,
    output logic        busy,
    output logic        feed_en,
    output logic [1:0]  denom_sel,
    output logic        done,
    output logic        fault,
    output logic [1:0]  error_code,
    output logic [7:0]  notes_out,
    output logic [2:0]  state
);

    state_e      state_q, state_d;
    logic [7:0]  cas_q  [3];
    logic [7:0]  cas_d  [3];
    logic [7:0]  plan_q [3];
    logic [7:0]  plan_d [3];
    logic [15:0] rem_q, rem_d;
    logic [7:0]  notes_q, notes_d;
    logic [1:0]  err_q, err_d;
    logic [1:0]  cur_q, cur_d;
    logic [9:0]  total;
    logic [1:0]  pick;
    logic        expired;

    note_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clock   (clock),
        .reset   (reset),
        .load    (state_q == S_FEED),
        .run     (state_q == S_WAIT_ACK),
        .expired (expired)
    );

    assign total = {2'b0, plan_q[0]} + {2'b0, plan_q[1]}
                 + {2'b0, plan_q[2]};
    assign pick  = pick_denom(plan_q[0], plan_q[1]);

    always_comb begin
        state_d = state_q;
        cas_d   = cas_q;
        plan_d  = plan_q;
        rem_d   = rem_q;
        notes_d = notes_q;
        err_d   = err_q;
        cur_d   = cur_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    rem_d   = amount;
                    notes_d = 8'd0;
                    err_d   = E_NONE;
                    plan_d  = '{default: 8'd0};
                    state_d = S_CHECK;
                end else if (load && load_sel != 2'd3) begin
                    cas_d[load_sel] = load_count;
                end
            end
            S_CHECK: begin
                if (rem_q == 16'd0) begin
                    err_d   = E_LIMIT;
                    state_d = S_FAULT;
                end else begin
                    state_d = S_PLAN;
                end
            end
            S_PLAN: begin
                // Limit is checked first so an exact fit over the cap still aborts.
                if (total > 10'(MAX_NOTES)) begin
                    err_d   = E_LIMIT;
                    state_d = S_FAULT;
                end else if (rem_q == 16'd0) begin
                    state_d = S_FEED;
                end else if (rem_q >= VAL500 && plan_q[0] < cas_q[0]) begin
                    plan_d[0] = plan_q[0] + 8'd1;
                    rem_d     = rem_q - VAL500;
                end else if (rem_q >= VAL200 && plan_q[1] < cas_q[1]) begin
                    plan_d[1] = plan_q[1] + 8'd1;
                    rem_d     = rem_q - VAL200;
                end else if (rem_q >= VAL100 && plan_q[2] < cas_q[2]) begin
                    plan_d[2] = plan_q[2] + 8'd1;
                    rem_d     = rem_q - VAL100;
                end else begin
                    err_d   = E_NOTES;
                    state_d = S_FAULT;
                end
            end
            S_FEED: begin
                cur_d   = pick;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (note_ack) begin
                    if (cas_q[cur_q] != 8'd0)
                        cas_d[cur_q] = cas_q[cur_q] - 8'd1;
                    if (plan_q[cur_q] != 8'd0)
                        plan_d[cur_q] = plan_q[cur_q] - 8'd1;
                    notes_d = notes_q + 8'd1;
                    state_d = (total > 10'd1) ? S_FEED : S_DONE;
                end else if (expired) begin
                    err_d   = E_JAM;
                    state_d = S_FAULT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cas_q   <= '{default: 8'd0};
            plan_q  <= '{default: 8'd0};
            rem_q   <= 16'd0;
            notes_q <= 8'd0;
            err_q   <= E_NONE;
            cur_q   <= D500;
        end else begin
            state_q <= state_d;
            cas_q   <= cas_d;
            plan_q  <= plan_d;
            rem_q   <= rem_d;
            notes_q <= notes_d;
            err_q   <= err_d;
            cur_q   <= cur_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign feed_en    = (state_q == S_FEED);
    assign denom_sel  = (state_q == S_FEED) ? pick : cur_q;
    assign done       = (state_q == S_DONE);
    assign fault      = (state_q == S_FAULT);
    assign error_code = err_q;
    assign notes_out  = notes_q;
    assign state      = state_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed self-checking bench for dispense_sequencer.
// Covers dispense, planning failures, jam timeout and reset.
module tb_dispense_sequencer;

    logic        clock = 0;
    logic        reset = 1;
    logic        req = 0;
    logic [15:0] amount = 0;
    logic        note_ack = 0;
    logic        load = 0;
    logic [1:0]  load_sel = 0;
    logic [7:0]  load_count = 0;
    logic        busy, feed_en, done, fault;
    logic [1:0]  denom_sel, error_code;
    logic [7:0]  notes_out;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    int          nfeed, done_cyc, fault_cyc, wait_cyc;
    logic [15:0] seq;

    dispense_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .amount     (amount),
        .note_ack   (note_ack),
        .load       (load),
        .load_sel   (load_sel),
        .load_count (load_count),
        .busy       (busy),
        .feed_en    (feed_en),
        .denom_sel  (denom_sel),
        .done       (done),
        .fault      (fault),
        .error_code (error_code),
        .notes_out  (notes_out),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_cas(input logic [1:0] sel, input logic [7:0] cnt);
        load = 1; load_sel = sel; load_count = cnt;
        tick();
        load = 0;
    endtask

    task automatic chk_cas(input string tag, input logic [7:0] c0,
                           input logic [7:0] c1, input logic [7:0] c2);
        chk({tag, "_c500"}, 32'(dut.cas_q[0]), 32'(c0));
        chk({tag, "_c200"}, 32'(dut.cas_q[1]), 32'(c1));
        chk({tag, "_c100"}, 32'(dut.cas_q[2]), 32'(c2));
    endtask

    task automatic run_txn(input logic [15:0] amt, input int ack_dly,
                           output int nf, output logic [15:0] sq,
                           output int dc, output int fc, output int wc);
        int since;
        nf = 0; sq = 0; dc = 0; fc = 0; wc = 0; since = -1;
        req = 1; amount = amt;
        tick();
        req = 0;
        for (int k = 1; k <= 400; k++) begin
            if (state == 3'd4) wc++;
            if (feed_en) begin
                sq = {sq[13:0], denom_sel};
                nf++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (done)  dc = k;
            if (fault) fc = k;
            if (done || fault) break;
            note_ack = (ack_dly > 0 && since == ack_dly);
            tick();
        end
        note_ack = 0;
        chk("txn_end", 32'(dc != 0 || fc != 0), 32'd1);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", 32'({feed_en, done, fault, denom_sel}), 0);
        chk("rst_err", 32'(error_code), 0);
        chk("rst_notes", 32'(notes_out), 0);
        chk_cas("rst", 0, 0, 0);
        reset = 0;
        tick();

        load_cas(0, 10);
        load_cas(1, 10);
        load_cas(2, 10);
        load_cas(3, 77);
        chk_cas("load", 10, 10, 10);

        run_txn(17, 2, nfeed, seq, done_cyc, fault_cyc, wait_cyc);
        chk("d17_nfeed", 32'(nfeed), 4);
        chk("d17_seq", 32'(seq[7:0]), 32'(8'b00_00_00_01));
        chk("d17_done", 32'(done_cyc != 0), 1);
        chk("d17_nofault", 32'(fault_cyc), 0);
        chk("d17_notes", 32'(notes_out), 4);
        chk("d17_err", 32'(error_code), 0);
        chk("d17_idle", 32'(state), 0);
        chk_cas("d17", 7, 9, 10);
        tick();
        tick();
        chk("d17_notes_hold", 32'(notes_out), 4);

        load_cas(0, 0);
        load_cas(1, 0);
        load_cas(2, 2);
        run_txn(3, 2, nfeed, seq, done_cyc, fault_cyc, wait_cyc);
        chk("a3_fault", 32'(fault_cyc != 0), 1);
        chk("a3_err", 32'(error_code), 2);
        chk("a3_nfeed", 32'(nfeed), 0);
        chk_cas("a3", 0, 0, 2);

        run_txn(0, 2, nfeed, seq, done_cyc, fault_cyc, wait_cyc);
        chk("a0_fault_cyc", 32'(fault_cyc), 2);
        chk("a0_err", 32'(error_code), 1);
        tick();
        tick();
        chk("a0_err_hold", 32'(error_code), 1);

        load_cas(0, 60);
        run_txn(250, 2, nfeed, seq, done_cyc, fault_cyc, wait_cyc);
        chk("a250_fault", 32'(fault_cyc != 0), 1);
        chk("a250_err", 32'(error_code), 1);
        chk("a250_nfeed", 32'(nfeed), 0);
        chk("a250_c500", 32'(dut.cas_q[0]), 60);

        load_cas(0, 1);
        run_txn(5, 0, nfeed, seq, done_cyc, fault_cyc, wait_cyc);
        chk("jam_fault", 32'(fault_cyc != 0), 1);
        chk("jam_err", 32'(error_code), 3);
        chk("jam_wait", 32'(wait_cyc), 16);
        chk("jam_nfeed", 32'(nfeed), 1);
        chk("jam_notes", 32'(notes_out), 0);
        chk("jam_c500", 32'(dut.cas_q[0]), 1);

        req = 1; amount = 5;
        tick();
        req = 0;
        for (int k = 0; k < 20 && state != 3'd4; k++) tick();
        chk("ra_wait", 32'(state), 4);
        load = 1; load_sel = 1; load_count = 99;
        req = 1; amount = 0;
        note_ack = 0;
        tick();
        load = 0; req = 0;
        chk("busy_load_ign", 32'(dut.cas_q[1]), 0);
        chk("busy_req_ign", 32'(state), 4);
        chk("busy_hi", 32'(busy), 1);
        reset = 1;
        tick();
        reset = 0;
        chk("ra_state", 32'(state), 0);
        chk("ra_busy", 32'(busy), 0);
        chk("ra_err", 32'(error_code), 0);
        chk_cas("ra", 0, 0, 0);
        chk("ra_plan", 32'({dut.plan_q[0], dut.plan_q[1], dut.plan_q[2]}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispense_sequencer.md
DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles waited for note_ack per note.
REQ-002 SHALL have parameter MAX_NOTES, default 40, max notes per transaction.
REQ-003 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  start request; sampled in IDLE only.
REQ-006 SHALL have port amount  input  16  withdrawal in units of 100; sampled with req.
REQ-007 SHALL have port note_ack  input  1  note sensor pulse: one note passed the exit.
REQ-008 SHALL have ports load, load_sel[1:0], load_count[7:0]  input  cassette refill strobe, denomination, new count.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have ports feed_en  output  1  and denom_sel  output  2  one-cycle feed pulse; 0=500, 1=200, 2=100.
REQ-011 SHALL have ports done, fault  output  1  each; one-cycle completion and abort pulses.
REQ-012 SHALL have port error_code  output  2  0 none, 1 bad amount/limit, 2 insufficient notes, 3 jam.
REQ-013 SHALL have ports notes_out  output  8  notes dispensed this transaction, and state  output  3  current FSM state.

Function
REQ-014 SHALL implement states IDLE, CHECK, PLAN, FEED, WAIT_ACK, DONE, FAULT.
REQ-015 IDLE: req=1 -> latch amount, clear notes_out and error_code, go CHECK next cycle.
REQ-016 IDLE: load=1 with req=0 -> cassette[load_sel] <= load_count; load_sel=3 ignored; req=1 wins over load.
REQ-017 load and req outside IDLE SHALL be ignored.
REQ-018 CHECK: amount==0 -> FAULT, error 1; else PLAN.
REQ-019 PLAN: one greedy step per cycle on remainder rem: rem>=5 and plan5<cnt500 -> plan5++, rem-=5; else rem>=2 and plan2<cnt200 -> plan2++, rem-=2; else rem>=1 and plan1<cnt100 -> plan1++, rem-=1.
REQ-020 PLAN: rem==0 -> FEED; no step possible with rem>0 -> FAULT, error 2; planned total > MAX_NOTES -> FAULT, error 1.
REQ-021 No note SHALL be fed unless the full plan succeeded.
REQ-022 FEED: one-cycle feed_en with denom_sel of highest denomination with plan>0; go WAIT_ACK.
REQ-023 WAIT_ACK: note_ack -> decrement that cassette and plan count, notes_out++; plans remain -> FEED, else DONE.
REQ-024 WAIT_ACK: TIMEOUT cycles without note_ack -> FAULT, error 3; cassette not decremented for that note.
REQ-025 note_ack outside WAIT_ACK SHALL be ignored.
REQ-026 DONE: done=1 one cycle, then IDLE. FAULT: fault=1 one cycle, then IDLE.
REQ-027 error_code SHALL hold until next accepted req; notes_out SHALL hold after DONE/FAULT.
REQ-028 Cassette counts SHALL saturate at 0, never wrap.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE from any state, including mid-feed.
REQ-030 Reset values: busy, feed_en, done, fault = 0; denom_sel, error_code, notes_out, state = 0; all cassette counts and plan counts = 0; timeout counter = 0.

Structure
REQ-031 Shared package SHALL hold state encoding, denomination codes (0/1/2), denomination values (5/2/1 units) and error codes.
REQ-032 One sub-module, note_timeout_counter (load, run, expired), SHALL implement the TIMEOUT watchdog.
REQ-033 Cassette counts SHALL be internal registers, 8 bits each.

Verification
REQ-034 Load 500x10, 200x10, 100x10; req amount=17 -> feeds 500,500,500,200; ack each in 2 cycles -> done, notes_out=4, counts 7/9/10.
REQ-035 Cassettes 0/0/2; amount=3 -> FAULT error 2, no feed_en pulse, counts unchanged.
REQ-036 amount=0 -> FAULT error 1 two cycles after req; amount=250 with 500x60 loaded -> FAULT error 1 (50 > MAX_NOTES).
REQ-037 amount=5, 500x1 loaded, no note_ack -> FAULT error 3 after 16 cycles in WAIT_ACK, count stays 1.
REQ-038 Reset asserted during WAIT_ACK -> next cycle state=IDLE, busy=0, all counts 0; req during busy and load during busy ignored.
